// File: rtl/eight_way_dispatch_scheduler_pkg.sv
// Shared definitions for the eight-way dispatch scheduler.
//   N_OUT         number of destination channels
//   SEL_W         width of a channel index
//   sched_state_t scheduler FSM encoding
//   sel_inc       next channel index, wrapping 7 -> 0
package dispatch_sched_pkg;

    localparam int unsigned N_OUT = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } sched_state_t;

    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/eight_way_dispatch_scheduler_if.sv
// Producer/consumer bundle for the eight-way dispatch scheduler.
//   IN_VALID/IN_READY/IN_DATA/IN_DEST/MODE  producer side handshake and word
//   OUT_DATA/OUT_VALID/OUT_READY            eight-channel broadcast side
//   SELECT/BUSY/DROP_COUNT                  status
// master: the environment (producer + channels); slave: the scheduler.
interface eight_way_dispatch_scheduler_if
    import dispatch_sched_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);

    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic [SEL_W-1:0]  IN_DEST;
    logic              MODE;
    logic [DATA_W-1:0] OUT_DATA;
    logic [N_OUT-1:0]  OUT_VALID;
    logic [N_OUT-1:0]  OUT_READY;
    logic [SEL_W-1:0]  SELECT;
    logic              BUSY;
    logic [CNT_W-1:0]  DROP_COUNT;

    modport master (
        output IN_VALID, IN_DATA, IN_DEST, MODE, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_VALID, SELECT, BUSY, DROP_COUNT
    );

    modport slave (
        input  IN_VALID, IN_DATA, IN_DEST, MODE, OUT_READY,
        output IN_READY, OUT_DATA, OUT_VALID, SELECT, BUSY, DROP_COUNT
    );

endinterface

// File: rtl/eight_way_dispatch_scheduler_demux.sv
// 1-to-8 demultiplexer: routes IN to OUT[SELECT], all other outputs low.
//   IN      1  value to route
//   SELECT  3  output index
//   OUT     8  one-hot (or zero) result
module THREE_BITS_SELECT_EIGHT_DEMUX_MODULE (
    input  logic       IN,
    input  logic [2:0] SELECT,
    output logic [7:0] OUT
);

    always_comb begin
        OUT         = '0;
        OUT[SELECT] = IN;
    end

endmodule

// File: rtl/eight_way_dispatch_scheduler_rr.sv
// Round-robin search: first index at or after PTR (mod 8) whose READY bit is set.
//   PTR    3  search start
//   READY  8  per-channel ready
//   IDX    3  chosen index (PTR when none ready)
//   FOUND  1  at least one READY bit set
module rr_next_ready_finder
    import dispatch_sched_pkg::*;
(
    input  logic [SEL_W-1:0] PTR,
    input  logic [N_OUT-1:0] READY,
    output logic [SEL_W-1:0] IDX,
    output logic             FOUND
);

    logic [2*N_OUT-1:0] ready_dbl;
    logic [N_OUT-1:0]   ready_rot;
    logic [SEL_W-1:0]   offset;

    // Rotate so PTR lands on bit 0, pick the lowest set bit, then add PTR back.
    assign ready_dbl = {READY, READY};
    assign ready_rot = ready_dbl[PTR +: N_OUT];

    always_comb begin
        offset = '0;
        for (int unsigned i = N_OUT; i > 0; i--) begin
            if (ready_rot[i-1]) begin
                offset = SEL_W'(i - 1);
            end
        end
    end

    assign IDX   = PTR + offset;
    assign FOUND = |READY;

endmodule

// File: rtl/eight_way_dispatch_scheduler.sv
// Captures one word at a time from a single producer and presents it to one of
// eight channels (addressed or round-robin), holding it until that channel
// accepts or the wait limit expires, in which case the word is dropped and counted.
//   CLK, RESET   clock and synchronous active-high reset
//   bus (slave)  producer handshake, broadcast data, one-hot valid, status
// Parameters: DATA_W word width, TIMEOUT hold limit in cycles (0 = unlimited),
// CNT_W width of the saturating drop counter.
module eight_way_dispatch_scheduler
    import dispatch_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                          CLK,
    input  logic                          RESET,
    eight_way_dispatch_scheduler_if.slave bus
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t      state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              mode_q, mode_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              in_ready;
    logic              busy;
    logic              accept;
    logic              timeout_hit;
    logic              holding;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_found;

    rr_next_ready_finder u_rr (
        .PTR   (rr_ptr_q),
        .READY (bus.OUT_READY),
        .IDX   (rr_idx),
        .FOUND (rr_found)
    );

    assign holding     = (state_q == HOLD);
    assign accept      = holding && bus.OUT_READY[sel_q];
    // The final wait slot is the count TIMEOUT-1; accept in that slot still wins.
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

    THREE_BITS_SELECT_EIGHT_DEMUX_MODULE u_demux (
        .IN     (holding),
        .SELECT (sel_q),
        .OUT    (bus.OUT_VALID)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.IN_VALID) state_d = HOLD;
            HOLD: begin
                if (accept) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = DROP;
                end
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (state_q == IDLE) begin
            in_ready = 1'b1;
            busy     = 1'b0;
        end
    end

    // Datapath next-state
    always_comb begin
        data_d     = data_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        mode_d     = mode_q;
        wait_d     = wait_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    data_d = bus.IN_DATA;
                    mode_d = bus.MODE;
                    wait_d = '0;
                    if (bus.MODE) begin
                        sel_d = rr_found ? rr_idx : rr_ptr_q;
                    end else begin
                        sel_d = bus.IN_DEST;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    if (mode_q) begin
                        rr_ptr_d = sel_inc(sel_q);
                    end
                end else if (!timeout_hit && (TIMEOUT != 0)) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DROP: begin
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q     <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            mode_q     <= 1'b0;
            wait_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            mode_q     <= mode_d;
            wait_q     <= wait_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.BUSY       = busy;
    assign bus.OUT_DATA   = data_q;
    assign bus.SELECT     = sel_q;
    assign bus.DROP_COUNT = drop_cnt_q;

endmodule

// File: tb/tb_eight_way_dispatch_scheduler.sv
module tb_eight_way_dispatch_scheduler;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    eight_way_dispatch_scheduler_if #(.DATA_W(8), .CNT_W(8)) ia ();
    eight_way_dispatch_scheduler_if #(.DATA_W(8), .CNT_W(2)) ib ();

    eight_way_dispatch_scheduler #(.DATA_W(8), .TIMEOUT(15), .CNT_W(8)) dut_a (
        .CLK   (clk),
        .RESET (rst_a),
        .bus   (ia)
    );

    eight_way_dispatch_scheduler #(.DATA_W(8), .TIMEOUT(3), .CNT_W(2)) dut_b (
        .CLK   (clk),
        .RESET (rst_b),
        .bus   (ib)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.IN_VALID = 1'b0; ia.IN_DATA = '0; ia.IN_DEST = '0; ia.MODE = 1'b0; ia.OUT_READY = '0;
        ib.IN_VALID = 1'b0; ib.IN_DATA = '0; ib.IN_DEST = '0; ib.MODE = 1'b0; ib.OUT_READY = '0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        check("rst_valid", ia.OUT_VALID, 8'h00);
        check("rst_busy", ia.BUSY, 1'b0);
        check("rst_drops", ia.DROP_COUNT, 8'd0);
        check("rst_in_ready", ia.IN_READY, 1'b1);
        check("rst_select", ia.SELECT, 3'd0);
        check("rst_data", ia.OUT_DATA, 8'h00);

        // Addressed delivery
        ia.MODE = 1'b0; ia.IN_DEST = 3'd5; ia.IN_DATA = 8'hA5; ia.OUT_READY = 8'h20; ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0; ia.IN_DATA = 8'hFF; ia.IN_DEST = 3'd2; ia.MODE = 1'b1;
        check("addr_valid", ia.OUT_VALID, 8'h20);
        check("addr_select", ia.SELECT, 3'd5);
        check("addr_data", ia.OUT_DATA, 8'hA5);
        check("addr_in_ready", ia.IN_READY, 1'b0);
        check("addr_busy", ia.BUSY, 1'b1);
        tick();
        check("addr_done_busy", ia.BUSY, 1'b0);
        check("addr_done_valid", ia.OUT_VALID, 8'h00);
        check("addr_hold_sel", ia.SELECT, 3'd5);
        check("addr_hold_data", ia.OUT_DATA, 8'hA5);

        // Round-robin with all channels ready: 0..7, 0, 1..5 leaves the pointer at 6
        ia.MODE = 1'b1; ia.OUT_READY = 8'hFF; ia.IN_VALID = 1'b1;
        for (int i = 0; i < 14; i++) begin
            ia.IN_DATA = 8'(i + 8'h10);
            tick();
            check("rr_select", ia.SELECT, 32'(i % 8));
            check("rr_valid", ia.OUT_VALID, 32'(8'h01 << (i % 8)));
            check("rr_data", ia.OUT_DATA, 32'(i + 8'h10));
            tick();
            check("rr_delivered", ia.BUSY, 1'b0);
        end

        // Skip not-ready channels from pointer 6: 6,7 not ready -> 0
        ia.OUT_READY = 8'b0000_0101;
        tick();
        ia.IN_VALID = 1'b0;
        check("skip_select", ia.SELECT, 3'd0);
        check("skip_valid", ia.OUT_VALID, 8'h01);
        tick();
        check("skip_delivered", ia.BUSY, 1'b0);
        // Pointer should now be 1
        ia.OUT_READY = 8'hFF; ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0;
        check("skip_ptr", ia.SELECT, 3'd1);
        tick();
        check("skip_ptr_done", ia.BUSY, 1'b0);

        // None ready: pointer (2) is used; other channels' ready is ignored
        ia.OUT_READY = 8'h00; ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0;
        check("none_select", ia.SELECT, 3'd2);
        ia.OUT_READY = 8'hFB;
        tick();
        check("ignore_busy", ia.BUSY, 1'b1);
        check("ignore_valid", ia.OUT_VALID, 8'h04);
        ia.OUT_READY = 8'h04;
        tick();
        check("none_delivered", ia.BUSY, 1'b0);
        check("none_drops", ia.DROP_COUNT, 8'd0);

        // Timeout: 15 cycles of valid, one drop cycle, then count 1
        ia.MODE = 1'b0; ia.IN_DEST = 3'd3; ia.OUT_READY = 8'h00; ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check("to_valid", ia.OUT_VALID, 8'h08);
            tick();
        end
        check("to_drop_valid", ia.OUT_VALID, 8'h00);
        check("to_drop_busy", ia.BUSY, 1'b1);
        check("to_drop_in_ready", ia.IN_READY, 1'b0);
        tick();
        check("to_idle_busy", ia.BUSY, 1'b0);
        check("to_count", ia.DROP_COUNT, 8'd1);

        // Accept in the 15th cycle wins over the timeout
        ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0;
        for (int k = 0; k < 14; k++) begin
            check("late_valid", ia.OUT_VALID, 8'h08);
            tick();
        end
        check("late_valid15", ia.OUT_VALID, 8'h08);
        ia.OUT_READY = 8'h08;
        tick();
        check("late_busy", ia.BUSY, 1'b0);
        check("late_count", ia.DROP_COUNT, 8'd1);
        ia.OUT_READY = 8'h00;
        tick();
        check("late_count2", ia.DROP_COUNT, 8'd1);

        // Reset in the middle of a hold
        ia.IN_DEST = 3'd1; ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0;
        check("mid_busy", ia.BUSY, 1'b1);
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        check("mid_rst_valid", ia.OUT_VALID, 8'h00);
        check("mid_rst_busy", ia.BUSY, 1'b0);
        check("mid_rst_drops", ia.DROP_COUNT, 8'd0);
        check("mid_rst_in_ready", ia.IN_READY, 1'b1);
        for (int k = 0; k < 20; k++) tick();
        check("mid_rst_no_drop", ia.DROP_COUNT, 8'd0);
        // Round-robin pointer returned to 0
        ia.MODE = 1'b1; ia.OUT_READY = 8'hFF; ia.IN_VALID = 1'b1;
        tick();
        ia.IN_VALID = 1'b0;
        check("mid_rst_rr", ia.SELECT, 3'd0);
        tick();

        // Saturating drop counter (TIMEOUT=3, CNT_W=2): 5 cycles per dropped word
        ib.MODE = 1'b0; ib.IN_DEST = 3'd0; ib.OUT_READY = 8'h00; ib.IN_VALID = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            for (int k = 0; k < 5; k++) tick();
            check("sat_busy", ib.BUSY, 1'b0);
            check("sat_count", ib.DROP_COUNT, (w < 3) ? 32'(w) : 32'd3);
        end
        ib.IN_VALID = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
